// File: rtl/base_pkg.sv
// Shared helpers for the base_* rotator family: lane-count width and the
// offset-advance step that turns a beat's tag and lane count into the next offset.
package base_pkg;

  localparam int unsigned MAX_WAYS      = 64;
  localparam int unsigned MAX_CNT_WIDTH = $clog2(MAX_WAYS + 1);

  function automatic int unsigned cntWidthOf(input int unsigned ways);
    return $clog2(ways + 1);
  endfunction

  // tag < ways and cnt <= ways, so the sum stays below 2*ways and one subtract wraps it.
  function automatic int unsigned nextOff(input int unsigned tag,
                                          input int unsigned cnt,
                                          input int unsigned ways);
    int unsigned sum;
    sum = tag + cnt;
    if (sum >= ways) sum = sum - ways;
    return sum;
  endfunction

endpackage

// File: rtl/base_skid.sv
// Generic one-entry skid slice: output register plus one overflow entry,
// with a registered ready so upstream never sees a combinational path from o_r.
module base_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_v,
  output logic         i_r,
  input  logic [W-1:0] i_d,
  output logic         o_v,
  input  logic         o_r,
  output logic [W-1:0] o_d
);

  logic         r_rdy;
  logic         r_ov;
  logic         r_sv;
  logic [W-1:0] r_od;
  logic [W-1:0] r_sd;
  logic         w_in;
  logic         w_load;
  logic         w_svNext;

  assign w_in     = i_v && r_rdy;
  assign w_load   = !r_ov || o_r;
  assign w_svNext = r_sv ? !w_load : (w_in && !w_load);

  // r_rdy is low whenever the skid entry is full, so w_in never coincides with r_sv.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy <= 1'b0;
      r_ov  <= 1'b0;
      r_sv  <= 1'b0;
      r_od  <= '0;
      r_sd  <= '0;
    end else begin
      r_rdy <= !w_svNext;
      r_sv  <= w_svNext;
      if (r_sv) begin
        if (w_load) begin
          r_ov <= 1'b1;
          r_od <= r_sd;
        end
      end else if (w_in) begin
        if (w_load) begin
          r_ov <= 1'b1;
          r_od <= i_d;
        end else begin
          r_sd <= i_d;
        end
      end else if (w_load) begin
        r_ov <= 1'b0;
      end
    end
  end

  assign i_r = r_rdy;
  assign o_v = r_ov;
  assign o_d = r_od;

endmodule

// File: rtl/base_rotr_seq.sv
// Rotate-amount sequencer: tags each accepted beat with the running lane offset.
// Define BASE_ROTR_SEQ_SKID_EN for a registered i_r backed by a base_skid slice.
module base_rotr_seq
  import base_pkg::*;
#(
  parameter int width     = 1,
  parameter int ways      = 2,
  parameter int sel_width = $clog2(ways),
  parameter int cnt_width = cntWidthOf(ways)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_v,
  output logic                   i_r,
  input  logic [ways*width-1:0]  i_d,
  input  logic [cnt_width-1:0]   i_cnt,
  input  logic                   i_clr,
  output logic                   o_v,
  input  logic                   o_r,
  output logic [ways*width-1:0]  o_d,
  output logic [0:sel_width-1]   o_sel,
  output logic [cnt_width-1:0]   o_cnt
);

  logic [sel_width-1:0] r_off;
  logic [sel_width-1:0] w_tag;
  logic [sel_width-1:0] w_offNext;
  logic                 w_acc;

  assign w_tag     = i_clr ? '0 : r_off;
  assign w_acc     = i_v && i_r;
  assign w_offNext = sel_width'(nextOff(32'(w_tag), 32'(i_cnt), ways));

  // A clear with no accepted beat still restarts the offset for the next beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_off <= '0;
    end else if (w_acc) begin
      r_off <= w_offNext;
    end else if (i_clr) begin
      r_off <= '0;
    end
  end

  a_cntLegal: assert property (@(posedge clk) disable iff (!rst_n)
                               w_acc |-> (32'(i_cnt) <= 32'(ways)));

`ifdef BASE_ROTR_SEQ_SKID_EN
  localparam int PW = ways*width + cnt_width + sel_width;

  logic [PW-1:0]        w_inPay;
  logic [PW-1:0]        w_outPay;
  logic [sel_width-1:0] w_sel;

  assign w_inPay = {i_d, i_cnt, w_tag};

  base_skid #(
    .W (PW)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .i_v   (i_v),
    .i_r   (i_r),
    .i_d   (w_inPay),
    .o_v   (o_v),
    .o_r   (o_r),
    .o_d   (w_outPay)
  );

  assign {o_d, o_cnt, w_sel} = w_outPay;
  assign o_sel               = w_sel;
`else
  logic                 r_rdy;
  logic                 r_v;
  logic [ways*width-1:0] r_d;
  logic [sel_width-1:0] r_sel;
  logic [cnt_width-1:0] r_cnt;

  // r_rdy keeps i_r low through reset and raises it on the first edge afterwards.
  assign i_r = r_rdy && (!r_v || o_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy <= 1'b0;
      r_v   <= 1'b0;
      r_sel <= '0;
      r_cnt <= '0;
    end else begin
      r_rdy <= 1'b1;
      if (w_acc) begin
        r_v   <= 1'b1;
        r_sel <= w_tag;
        r_cnt <= i_cnt;
      end else if (o_r) begin
        r_v   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) r_d <= i_d;
  end

  assign o_v   = r_v;
  assign o_d   = r_d;
  assign o_sel = r_sel;
  assign o_cnt = r_cnt;
`endif

endmodule

// File: doc/base_rotr_seq.md
BASE_ROTR_SEQ -- requirements
Module: base_rotr_seq

Interface
REQ-001 SHALL have parameter width, default 1; bits per lane.
REQ-002 SHALL have parameter ways, default 2; lanes per beat; legal range 2..64, any integer, not only powers of 2.
REQ-003 SHALL have parameter sel_width, default $clog2(ways); rotate-select width.
REQ-004 SHALL have parameter cnt_width, default $clog2(ways+1); lane-count width.
REQ-005 SHALL have port clk  input  1; the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n  input  1; reset, asynchronous assert, active-low.
REQ-007 SHALL have port i_v  input  1; input beat valid.
REQ-008 SHALL have port i_r  output  1; input beat ready.
REQ-009 SHALL have port i_d  input  ways*width; input lanes, lane k at bits [(k+1)*width-1:k*width].
REQ-010 SHALL have port i_cnt  input  cnt_width; number of meaningful lanes in beat, 0..ways.
REQ-011 SHALL have port i_clr  input  1; restart lane offset at 0.
REQ-012 SHALL have port o_v  output  1; output beat valid.
REQ-013 SHALL have port o_r  input  1; output beat ready, from the downstream rotator stage.
REQ-014 SHALL have port o_d  output  ways*width; registered copy of i_d.
REQ-015 SHALL have port o_sel  output  [0:sel_width-1]; rotate amount for this beat, unsigned binary, index 0 = MSB.
REQ-016 SHALL have port o_cnt  output  cnt_width; registered copy of i_cnt.

Function
REQ-017 SHALL accept a beat when i_v && i_r, and present it when o_v && o_r.
REQ-018 SHALL hold an internal offset register off, range 0..ways-1.
REQ-019 SHALL tag each accepted beat with o_sel = (i_clr ? 0 : off).
REQ-020 SHALL update off on acceptance to (tag + i_cnt) mod ways, computed as one conditional subtract of ways.
REQ-021 SHALL leave off unchanged for an accepted beat with i_cnt=0, passing that beat through with the current tag.
REQ-022 SHALL set off to 0 on the next edge when i_clr=1 and no beat is accepted.
REQ-023 SHALL have latency of exactly 1 cycle from acceptance to o_v.
REQ-024 SHALL sustain full throughput, one beat per cycle, when o_r is held high.
REQ-025 SHALL hold o_d, o_sel and o_cnt stable while o_v && !o_r.
REQ-026 SHALL never drop o_v without a handshake.
REQ-027 SHALL flag i_cnt > ways as illegal with a simulation assertion; RTL behaviour in that case is unspecified.
REQ-028 SHALL not let the values of i_d or i_cnt affect i_r.

Reset
REQ-029 SHALL, while rst_n=0, force o_v=0, off=0, i_r=0, skid buffer empty, o_sel=0, o_cnt=0.
REQ-030 SHALL leave o_d at don't-care in reset (no reset on the data path).
REQ-031 SHALL discard any in-flight beat on reset assertion mid-transfer.
REQ-032 SHALL raise i_r on the first edge after rst_n deasserts.

Configuration
REQ-033 SHALL, with macro BASE_ROTR_SEQ_SKID_EN defined, drive i_r from a flop and add a one-entry skid buffer holding d/cnt/sel, so that i_r has no combinational path from o_r.
REQ-034 SHALL, with BASE_ROTR_SEQ_SKID_EN undefined, drive i_r = !o_v || o_r combinationally, with no skid storage.
REQ-035 SHALL keep REQ-017..REQ-028 true in both configurations; with the skid buffer the beat order is preserved.

Structure
REQ-036 SHALL place the offset-advance function (tag, cnt, ways -> next offset) and the lane-count width constant in shared package base_pkg.
REQ-037 SHALL instantiate sub-module base_skid, a generic width-parameterised one-entry skid slice, only when BASE_ROTR_SEQ_SKID_EN is defined.

Verification
REQ-038 SHALL pass: ways=4, o_r=1, cnt sequence 3,3,2,4 -> o_sel 0,3,2,0, one beat per cycle.
REQ-039 SHALL pass: ways=5, cnt 4,4,4 -> o_sel 0,4,3 (wrap with non-power-of-2 ways).
REQ-040 SHALL pass: ways=4, off=3, accepted beat with i_clr=1, cnt=2 -> that beat o_sel=0, next beat o_sel=2; idle i_clr -> next beat o_sel=0.
REQ-041 SHALL pass: o_r=0 for 5 cycles with i_v=1 -> o_d/o_sel stable, at most 1 beat stored (2 with skid), no loss or duplication after o_r rises.
REQ-042 SHALL pass: rst_n pulsed low mid-stream with o_v=1 -> o_v=0 immediately, first post-reset beat o_sel=0.
REQ-043 SHALL pass: random i_v/o_r, random cnt 0..ways, against a scoreboard model of the offset in both macro settings -> exact match.
